// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Chip-level reset release sequencer, clocked from the always-on housekeeping
// clock. Qualifies the POR-good and pad-reset inputs through synchronizers and
// a clean-time filter, then releases the housekeeping, core and user-project
// domains in a fixed staggered order. Soft-reset and watchdog requests in RUN
// re-reset only core and user; housekeeping stays released. The cause of the
// most recent reset is held for firmware.
//
// Ports
//   clock         housekeeping clock
//   reset         asynchronous active-high reset (from the POR cell)
//   porb_l        POR good, active-high, asynchronous to clock
//   ext_resetn    pad reset, active-low, asynchronous to clock
//   soft_rst_req  single-cycle soft-reset request (clock domain)
//   wdt_expire    single-cycle watchdog expiry pulse (clock domain)
//   rst_hk_n      housekeeping domain reset, active-low
//   rst_core_n    CPU core domain reset, active-low
//   rst_user_n    user-project domain reset, active-low
//   rst_cause     last reset cause: 0 POR, 1 pad, 2 soft, 3 watchdog
//   seq_busy      high whenever the sequencer is not in RUN
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SOFT_HOLD   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       porb_l,
    input  logic       ext_resetn,
    input  logic       soft_rst_req,
    input  logic       wdt_expire,
    output logic       rst_hk_n,
    output logic       rst_core_n,
    output logic       rst_user_n,
    output logic [1:0] rst_cause,
    output logic       seq_busy
);

    localparam int MAX_AB  = (FILT_CYCLES > STAGE_GAP) ? FILT_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_AB > SOFT_HOLD) ? MAX_AB : SOFT_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SOFT_HOLD - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_FILTER,
        ST_REL_HK,
        ST_REL_CORE,
        ST_REL_USER,
        ST_RUN,
        ST_SOFT
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] por_sync;
    logic [SYNC_STAGES-1:0] pad_sync;
    logic                   por_ok;
    logic                   pad_ok;
    logic                   hard_bad;
    logic                   soft_req_p0;
    logic                   wdt_req_p0;

    // Synchronizers reset to 0 so both inputs read as "bad" until proven good.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            por_sync <= '0;
            pad_sync <= '0;
        end else begin
            por_sync <= {por_sync[SYNC_STAGES-2:0], porb_l};
            pad_sync <= {pad_sync[SYNC_STAGES-2:0], ext_resetn};
        end
    end

    assign por_ok   = por_sync[SYNC_STAGES-1];
    assign pad_ok   = pad_sync[SYNC_STAGES-1];
    assign hard_bad = !por_ok || !pad_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            rst_hk_n    <= 1'b0;
            rst_core_n  <= 1'b0;
            rst_user_n  <= 1'b0;
            rst_cause   <= 2'd0;
            seq_busy    <= 1'b1;
            soft_req_p0 <= 1'b0;
            wdt_req_p0  <= 1'b0;
        end else begin
            // Requests are captured only while in RUN, so anything raised
            // during a sequence is dropped rather than queued.
            soft_req_p0 <= soft_rst_req && (state == ST_RUN);
            wdt_req_p0  <= wdt_expire && (state == ST_RUN);

            if (state != ST_ASSERT && hard_bad) begin
                state      <= ST_ASSERT;
                cnt        <= '0;
                rst_hk_n   <= 1'b0;
                rst_core_n <= 1'b0;
                rst_user_n <= 1'b0;
                seq_busy   <= 1'b1;
                rst_cause  <= por_ok ? 2'd1 : 2'd0;
            end else begin
                case (state)
                    ST_ASSERT: begin
                        state <= ST_FILTER;
                        cnt   <= '0;
                    end
                    ST_FILTER: begin
                        if (cnt == FILT_LAST) begin
                            state    <= ST_REL_HK;
                            cnt      <= '0;
                            rst_hk_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REL_HK: begin
                        if (cnt == GAP_LAST) begin
                            state      <= ST_REL_CORE;
                            cnt        <= '0;
                            rst_core_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REL_CORE: begin
                        if (cnt == GAP_LAST) begin
                            state      <= ST_REL_USER;
                            cnt        <= '0;
                            rst_user_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REL_USER: begin
                        state    <= ST_RUN;
                        seq_busy <= 1'b0;
                    end
                    ST_RUN: begin
                        // Watchdog outranks a simultaneous soft request.
                        if (wdt_req_p0 || soft_req_p0) begin
                            state      <= ST_SOFT;
                            cnt        <= '0;
                            rst_core_n <= 1'b0;
                            rst_user_n <= 1'b0;
                            seq_busy   <= 1'b1;
                            rst_cause  <= wdt_req_p0 ? 2'd3 : 2'd2;
                        end
                    end
                    ST_SOFT: begin
                        // Housekeeping stays released; resume at the core stage.
                        if (cnt == HOLD_LAST) begin
                            state      <= ST_REL_CORE;
                            cnt        <= '0;
                            rst_core_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state      <= ST_ASSERT;
                        cnt        <= '0;
                        rst_hk_n   <= 1'b0;
                        rst_core_n <= 1'b0;
                        rst_user_n <= 1'b0;
                        seq_busy   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed power-up, fault, soft/watchdog and
// async-reset scenarios followed by a randomized phase, all compared every
// cycle against a timestamp-based reference model.
module tb_reset_sequencer;
    localparam int S    = 2;
    localparam int FILT = 16;
    localparam int GAP  = 8;
    localparam int HOLD = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       porb_l = 1'b1;
    logic       ext_resetn = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       wdt_expire = 1'b0;
    logic       rst_hk_n, rst_core_n, rst_user_n, seq_busy;
    logic [1:0] rst_cause;

    int n_chk  = 0;
    int n_fail = 0;

    reset_sequencer #(
        .SYNC_STAGES(S), .FILT_CYCLES(FILT), .STAGE_GAP(GAP), .SOFT_HOLD(HOLD)
    ) dut (
        .clock(clk), .reset(rst), .porb_l(porb_l), .ext_resetn(ext_resetn),
        .soft_rst_req(soft_rst_req), .wdt_expire(wdt_expire),
        .rst_hk_n(rst_hk_n), .rst_core_n(rst_core_n), .rst_user_n(rst_user_n),
        .rst_cause(rst_cause), .seq_busy(seq_busy)
    );

    always #5 clk = ~clk;

    // Reference model: expected outputs follow from timestamps of the last
    // hard event, filter completion, and soft-reset start.
    // phase 0: held in hard reset (asserting/filtering), 1: released after a
    // hard reset at edge tf, 2: released after a soft reset started at edge ts.
    logic [S-1:0] por_hist, pad_hist;
    int   mn, phase, hard_t0, tf, ts, run_at, m_cause, pend_cause;
    logic pend;
    logic m_hk, m_core, m_user, m_busy;

    task automatic model_outputs();
        m_hk = 1'b0; m_core = 1'b0; m_user = 1'b0; m_busy = 1'b1;
        if (phase == 1) begin
            m_hk   = 1'b1;
            m_core = (mn >= tf + GAP);
            m_user = (mn >= tf + 2 * GAP);
            m_busy = (mn < run_at);
        end else if (phase == 2) begin
            m_hk   = 1'b1;
            m_core = (mn >= ts + HOLD);
            m_user = (mn >= ts + HOLD + GAP);
            m_busy = (mn < run_at);
        end
    endtask

    task automatic model_reset();
        mn = 0; phase = 0; hard_t0 = 0; tf = 0; ts = 0; run_at = 0;
        m_cause = 0; pend = 1'b0; pend_cause = 0;
        por_hist = '0; pad_hist = '0;
        model_outputs();
    endtask

    task automatic model_update();
        logic por_ok, pad_ok, bad, in_assert, run_pre;
        por_ok = por_hist[S-1];
        pad_ok = pad_hist[S-1];
        bad    = !por_ok || !pad_ok;
        mn++;
        in_assert = (phase == 0) && (mn - 1 == hard_t0);
        run_pre   = (phase != 0) && (mn - 1 >= run_at);
        if (!in_assert && bad) begin
            phase   = 0;
            hard_t0 = mn;
            m_cause = por_ok ? 1 : 0;
        end else if (phase == 0) begin
            // Clean evaluations so far are edges hard_t0+2 .. mn.
            if (!in_assert && (mn - hard_t0 - 1 == FILT)) begin
                phase  = 1;
                tf     = mn;
                run_at = mn + 2 * GAP + 1;
            end
        end else if (pend && run_pre) begin
            phase   = 2;
            ts      = mn;
            run_at  = mn + HOLD + GAP + 1;
            m_cause = pend_cause;
        end
        pend       = run_pre && (soft_rst_req || wdt_expire);
        pend_cause = wdt_expire ? 3 : 2;
        por_hist   = {por_hist[S-2:0], porb_l};
        pad_hist   = {pad_hist[S-2:0], ext_resetn};
        model_outputs();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("hk_n",   32'(rst_hk_n),   32'(m_hk));
        chk("core_n", 32'(rst_core_n), 32'(m_core));
        chk("user_n", 32'(rst_user_n), 32'(m_user));
        chk("busy",   32'(seq_busy),   32'(m_busy));
        chk("cause",  32'(rst_cause),  32'(m_cause));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; porb_l = 1'b1; ext_resetn = 1'b1;
        soft_rst_req = 1'b0; wdt_expire = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    task automatic measure_powerup(output int e_hk, output int e_core,
                                   output int e_user, output int e_idle);
        e_hk = -1; e_core = -1; e_user = -1; e_idle = -1;
        repeat (45) begin
            step();
            if (e_hk   < 0 && rst_hk_n   === 1'b1) e_hk   = mn;
            if (e_core < 0 && rst_core_n === 1'b1) e_core = mn;
            if (e_user < 0 && rst_user_n === 1'b1) e_user = mn;
            if (e_idle < 0 && seq_busy   === 1'b0) e_idle = mn;
        end
    endtask

    task automatic measure_soft(input logic both, input int second_at, output int k,
                                output int cf, output int cr, output int ur,
                                output logic hk_dropped);
        soft_rst_req = 1'b1; wdt_expire = both;
        step();
        k = mn;
        soft_rst_req = 1'b0; wdt_expire = 1'b0;
        cf = -1; cr = -1; ur = -1; hk_dropped = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (i == second_at) soft_rst_req = 1'b1;
            step();
            soft_rst_req = 1'b0;
            if (rst_hk_n !== 1'b1) hk_dropped = 1'b1;
            if (cf < 0 && rst_core_n === 1'b0) cf = mn;
            else if (cf >= 0 && cr < 0 && rst_core_n === 1'b1) cr = mn;
            if (cr >= 0 && ur < 0 && rst_user_n === 1'b1) ur = mn;
        end
    endtask

    initial begin
        int   e_hk, e_core, e_user, e_idle, k, cf, cr, ur, p, r, por_left, pad_left;
        logic hk_dropped, seen;

        // Power-up with defaults
        do_reset();
        measure_powerup(e_hk, e_core, e_user, e_idle);
        chk("pwr_hk_edge",   32'(e_hk),   32'(S + FILT + 1));
        chk("pwr_core_edge", 32'(e_core), 32'(S + FILT + 1 + GAP));
        chk("pwr_user_edge", 32'(e_user), 32'(S + FILT + 1 + 2 * GAP));
        chk("pwr_idle_edge", 32'(e_idle), 32'(S + FILT + 2 + 2 * GAP));
        chk("pwr_cause",     32'(rst_cause), 32'(0));

        // Soft reset in RUN
        measure_soft(1'b0, 0, k, cf, cr, ur, hk_dropped);
        chk("soft_core_fall", 32'(cf), 32'(k + 1));
        chk("soft_hold_len",  32'(cr - cf), 32'(HOLD));
        chk("soft_user_gap",  32'(ur - cr), 32'(GAP));
        chk("soft_hk_kept",   32'(hk_dropped), 32'(0));
        chk("soft_cause",     32'(rst_cause), 32'(2));

        // Simultaneous soft + watchdog, plus an ignored request during SOFT
        measure_soft(1'b1, 10, k, cf, cr, ur, hk_dropped);
        chk("both_core_fall", 32'(cf), 32'(k + 1));
        chk("both_hold_len",  32'(cr - cf), 32'(HOLD));
        chk("both_user_gap",  32'(ur - cr), 32'(GAP));
        chk("both_hk_kept",   32'(hk_dropped), 32'(0));
        chk("both_cause",     32'(rst_cause), 32'(3));

        // Pad reset pulse of 3 cycles in RUN
        p = mn;
        ext_resetn = 1'b0;
        repeat (3) step();
        ext_resetn = 1'b1;
        chk("pad_edge",   32'(mn - p), 32'(S + 1));
        chk("pad_hk",     32'(rst_hk_n),   32'(0));
        chk("pad_core",   32'(rst_core_n), 32'(0));
        chk("pad_user",   32'(rst_user_n), 32'(0));
        chk("pad_cause",  32'(rst_cause),  32'(1));
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (rst_core_n === 1'b1) seen = 1'b1;
        end
        chk("pad_replay_core", 32'(seen), 32'(1));

        // Asynchronous reset in the middle of REL_CORE
        repeat (3) step();
        chk("mid_core_user_held", 32'(rst_user_n), 32'(0));
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_hk",    32'(rst_hk_n),   32'(0));
        chk("arst_core",  32'(rst_core_n), 32'(0));
        chk("arst_user",  32'(rst_user_n), 32'(0));
        chk("arst_busy",  32'(seq_busy),   32'(1));
        chk("arst_cause", 32'(rst_cause),  32'(0));
        do_reset();
        measure_powerup(e_hk, e_core, e_user, e_idle);
        chk("rep_hk_edge",   32'(e_hk),   32'(S + FILT + 1));
        chk("rep_core_edge", 32'(e_core), 32'(S + FILT + 1 + GAP));
        chk("rep_user_edge", 32'(e_user), 32'(S + FILT + 1 + 2 * GAP));
        chk("rep_idle_edge", 32'(e_idle), 32'(S + FILT + 2 + 2 * GAP));

        // POR glitches every 10 cycles during FILTER; last one after edge 45
        do_reset();
        e_hk = -1;
        for (int c = 0; c < 75; c++) begin
            porb_l = ((c % 10) == 5 && c <= 45) ? 1'b0 : 1'b1;
            step();
            if (e_hk < 0 && rst_hk_n === 1'b1) e_hk = mn;
        end
        porb_l = 1'b1;
        chk("glitch_hk_edge", 32'(e_hk), 32'(45 + S + 1 + FILT + 1));

        // Randomized phase
        do_reset();
        por_left = 0;
        pad_left = 0;
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(0, 299));
            porb_l = 1'b1;
            ext_resetn = 1'b1;
            if (por_left > 0) begin
                porb_l = 1'b0; por_left--;
            end else if (r == 0) begin
                porb_l = 1'b0; por_left = int'($urandom_range(0, 3));
            end
            if (pad_left > 0) begin
                ext_resetn = 1'b0; pad_left--;
            end else if (r == 1) begin
                ext_resetn = 1'b0; pad_left = int'($urandom_range(0, 3));
            end
            soft_rst_req = (r >= 2 && r < 10);
            wdt_expire   = (r >= 8 && r < 14);
            if (r == 14) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                #1;
                rst = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
